// File: rtl/bandit_pkg.sv
// Shared constants, FSM encoding and LFSR step function for the bandit environment.
package bandit_pkg;

  localparam logic [7:0]  REWARD_WIN  = 8'hFF;
  localparam logic [7:0]  REWARD_LOSS = 8'h00;
  localparam logic [15:0] LFSR_TAPS   = 16'hB400;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    HOLD = 2'd2
  } state_t;

  // One step of a right-shifting Galois LFSR: the bit shifted out selects the tap XOR.
  function automatic logic [15:0] lfsr_step(input logic [15:0] value, input logic [15:0] taps);
    lfsr_step = value[0] ? ((value >> 1) ^ taps) : (value >> 1);
  endfunction

endpackage

// File: rtl/bandit_env_lfsr.sv
// 16-bit Galois LFSR that advances only when enabled; the random source for reward draws.
module lfsr
  import bandit_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1,
  parameter logic [15:0] TAPS = LFSR_TAPS
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  output logic [15:0] value
);

  // LFSR state register
  always_ff @(posedge clock) begin
    if (reset) begin
      value <= SEED;
    end else if (enable) begin
      value <= lfsr_step(value, TAPS);
    end else begin
      value <= value;
    end
  end

endmodule

// File: rtl/bandit_env.sv
// Multi-armed bandit environment: accepts an arm index, draws a Bernoulli reward from an LFSR.
module bandit_env
  import bandit_pkg::*;
#(
  parameter int              ARMS  = 4,
  parameter logic [8*ARMS-1:0] PROBS = {8'hC0, 8'h80, 8'h40, 8'h20},
  parameter logic [15:0]     SEED  = 16'hACE1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        action_valid,
  input  logic [7:0]  action_data,
  output logic        action_ready,
  output logic        reward_valid,
  output logic [7:0]  reward_data,
  input  logic        reward_ready,
  output logic        error,
  output logic [15:0] count
);

  state_t      state_r;
  state_t      state_next_s;
  logic [7:0]  arm_r;
  logic [7:0]  thresh_s;
  logic        in_range_s;
  logic        win_s;
  logic        action_hs_s;
  logic [15:0] lfsr_value_s;

  assign action_hs_s = action_valid && action_ready;

  lfsr #(
    .SEED (SEED),
    .TAPS (LFSR_TAPS)
  ) u_lfsr (
    .clock  (clock),
    .reset  (reset),
    .enable (state_r == DRAW),
    .value  (lfsr_value_s)
  );

  // Threshold lookup and win decision for the latched arm
  always_comb begin
    thresh_s = 8'h00;
    for (int i = 0; i < ARMS; i++) begin
      if (arm_r == 8'(i)) begin
        thresh_s = PROBS[i*8 +: 8];
      end else begin
        thresh_s = thresh_s;
      end
    end
    in_range_s = (arm_r < 8'(ARMS));
    win_s      = in_range_s && (lfsr_value_s[7:0] < thresh_s);
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (action_hs_s) begin
          state_next_s = DRAW;
        end else begin
          state_next_s = IDLE;
        end
      end
      DRAW: state_next_s = HOLD;
      HOLD: begin
        if (reward_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = HOLD;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State, handshake outputs, reward, error and counter registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= IDLE;
      action_ready <= 1'b1;
      reward_valid <= 1'b0;
      reward_data  <= REWARD_LOSS;
      error        <= 1'b0;
      count        <= 16'h0000;
      arm_r        <= 8'h00;
    end else begin
      state_r      <= state_next_s;
      // Ready/valid come from the next state so they never see the partner's handshake input combinationally
      action_ready <= (state_next_s == IDLE);
      reward_valid <= (state_next_s == HOLD);
      if (action_hs_s) begin
        arm_r <= action_data;
      end
      if (state_r == DRAW) begin
        reward_data <= win_s ? REWARD_WIN : REWARD_LOSS;
        if (!in_range_s) begin
          error <= 1'b1;
        end
      end
      if (action_hs_s && (count != 16'hFFFF)) begin
        count <= count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_bandit_env.sv
// Randomized + directed scoreboard bench for bandit_env against a behavioural LFSR/reward model.
module tb_bandit_env;

  localparam int ARMS = 4;
  localparam logic [15:0] SEED = 16'hACE1;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        action_valid = 1'b0;
  logic [7:0]  action_data = 8'h00;
  logic        action_ready;
  logic        reward_valid;
  logic [7:0]  reward_data;
  logic        reward_ready = 1'b0;
  logic        error;
  logic [15:0] count;

  bandit_env #(
    .ARMS  (ARMS),
    .PROBS ({8'h40, 8'hE1, 8'h80, 8'hF0}),
    .SEED  (SEED)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .action_valid (action_valid),
    .action_data  (action_data),
    .action_ready (action_ready),
    .reward_valid (reward_valid),
    .reward_data  (reward_data),
    .reward_ready (reward_ready),
    .error        (error),
    .count        (count)
  );

  always #5 clock = ~clock;

  int probs [ARMS] = '{8'hF0, 8'h80, 8'hE1, 8'h40};
  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  typedef struct { int data; int rise; } exp_t;
  exp_t q[$];
  int m_lfsr = 32'hACE1;
  int m_count = 0;
  int m_err = 0;
  int wins_model = 0;
  int wins_dut = 0;
  bit prev_valid = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int lfsr_next(input int v);
    return (v % 2 == 1) ? ((v / 2) ^ 32'hB400) : (v / 2);
  endfunction

  function automatic int model_reward(input int arm, input int l);
    if (arm < ARMS && (l % 256) < probs[arm]) return 255;
    return 0;
  endfunction

  // Monitor / scoreboard: samples on the falling edge, predicts on action handshakes, checks on rewards
  always @(negedge clock) begin
    exp_t e;
    check("count_track", count, m_count);
    if (reset) begin
      q.delete();
      m_lfsr = 32'hACE1;
      m_count = 0;
      m_err = 0;
      wins_model = 0;
      wins_dut = 0;
      prev_valid = 1'b0;
    end else begin
      if (reward_valid && !prev_valid) begin
        if (q.size() == 0) check("spurious_reward", 1, 0);
        else check("reward_latency", cyc, q[0].rise);
      end
      if (reward_valid && reward_ready) begin
        if (q.size() == 0) begin
          check("reward_queue_empty", 1, 0);
        end else begin
          e = q.pop_front();
          check("reward_data", reward_data, e.data);
          check("error_flag", error, m_err);
          if (reward_data == 8'hFF) wins_dut++;
        end
      end
      if (action_valid && action_ready) begin
        e.data = model_reward(action_data, m_lfsr);
        e.rise = cyc + 2;
        q.push_back(e);
        if (e.data == 255) wins_model++;
        if (action_data >= ARMS) m_err = 1;
        m_lfsr = lfsr_next(m_lfsr);
        if (m_count < 65535) m_count++;
      end
      prev_valid = reward_valid;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    action_valid = 1'b0;
  endtask

  task automatic send(input int arm);
    int t = 0;
    action_data = 8'(arm);
    action_valid = 1'b1;
    while (!action_ready && t < 100) begin
      tick(1);
      t++;
    end
    if (t >= 100) check("action_ready_timeout", 0, 1);
    tick(1);
    action_valid = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] held;
    int held_l;
    int t;
    tick(2);

    // Reset values, with a simultaneous action offered (reset wins)
    action_valid = 1'b1;
    action_data = 8'h00;
    do_reset();
    check("rst_action_ready", action_ready, 1);
    check("rst_reward_valid", reward_valid, 0);
    check("rst_reward_data", reward_data, 8'h00);
    check("rst_error", error, 0);
    check("rst_count", count, 0);
    check("rst_lfsr", dut.u_lfsr.value, SEED);
    tick(1);
    check("rst_priority_idle", action_ready, 1);

    // Win on first draw: E1 < F0
    reward_ready = 1'b1;
    do_reset();
    send(0);
    tick(1);
    check("first_win_valid", reward_valid, 1);
    check("first_win_data", reward_data, 8'hFF);
    check("first_lfsr_step", dut.u_lfsr.value, 16'hE270);
    tick(1);

    // Equal threshold is a loss: E1 < E1 false
    do_reset();
    send(2);
    tick(1);
    check("equal_loss_data", reward_data, 8'h00);
    tick(1);

    // Out-of-range arm, then error stays sticky
    send(9);
    tick(1);
    check("oob_data", reward_data, 8'h00);
    check("oob_error", error, 1);
    tick(1);
    send(1);
    tick(2);
    check("error_sticky", error, 1);

    // Stall in HOLD for 20 cycles with an action also offered
    reward_ready = 1'b0;
    send(1);
    tick(1);
    held = reward_data;
    held_l = dut.u_lfsr.value;
    action_valid = 1'b1;
    action_data = 8'h00;
    repeat (20) begin
      check("stall_valid", reward_valid, 1);
      check("stall_data", reward_data, held);
      check("stall_action_ready", action_ready, 0);
      check("stall_lfsr", dut.u_lfsr.value, held_l);
      tick(1);
    end
    action_valid = 1'b0;
    reward_ready = 1'b1;
    tick(2);

    // Reset while holding a reward discards it; next draw restarts from SEED
    reward_ready = 1'b0;
    send(0);
    tick(1);
    check("pre_reset_hold", reward_valid, 1);
    do_reset();
    check("reset_in_hold_valid", reward_valid, 0);
    check("reset_in_hold_count", count, 0);
    reward_ready = 1'b1;
    send(0);
    tick(1);
    check("post_reset_draw", reward_data, 8'hFF);
    tick(2);

    // Random traffic with random backpressure and arms including out-of-range
    do_reset();
    repeat (600) begin
      action_valid = 1'($urandom_range(0, 1));
      action_data = 8'($urandom_range(0, 9));
      reward_ready = ($urandom_range(0, 3) != 0);
      tick(1);
    end
    action_valid = 1'b0;
    reward_ready = 1'b1;
    tick(4);
    check("random_drain", q.size(), 0);

    // 1000 back-to-back actions to the 0x40-threshold arm
    do_reset();
    action_data = 8'h03;
    action_valid = 1'b1;
    t = 0;
    while (count < 16'd1000 && t < 4000) begin
      tick(1);
      t++;
    end
    action_valid = 1'b0;
    if (t >= 4000) check("b2b_timeout", 0, 1);
    tick(5);
    check("b2b_count", count, 1000);
    check("b2b_wins", wins_dut, wins_model);
    check("b2b_win_rate_plausible", (wins_dut > 150 && wins_dut < 350), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
